// File: rtl/adjust_pkg.sv
// ----------------------------------------------------------------------------
// adjust_pkg
// Shared constants for the brightness/colour adjust control stage.
//   LVL_W / LVL_MAX : width and ceiling of a gain level (0..7)
//   sel_t           : channel-select encoding (ALL, R, G, B)
// ----------------------------------------------------------------------------
package adjust_pkg;

   localparam int                LVL_W   = 3;
   localparam logic [LVL_W-1:0]  LVL_MAX = 3'd7;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_ALL = 2'd0;
   localparam sel_t SEL_R   = 2'd1;
   localparam sel_t SEL_G   = 2'd2;
   localparam sel_t SEL_B   = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Synchronizes one active-low push-button, debounces it and emits a
// one-cycle press pulse when the debounced level falls (1 -> 0).
// Ports:
//   clk      : pixel clock
//   rst_n    : asynchronous active-low reset
//   i_key_n  : raw button, active-low, asynchronous to clk
//   o_press  : one-cycle pulse per accepted press
// ----------------------------------------------------------------------------
module key_debounce #(
   parameter int DB_CYCLES = 750000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n,
   output logic o_press
);

   localparam int               CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             w_differs;
   logic             w_accept;

   assign w_differs = (r_sync2 != r_stable);
   assign w_accept  = w_differs && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         // Any return to the stable level restarts the qualification window.
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         // Accepting a low level while stable was high is the press edge.
         r_press <= w_accept & ~r_sync2;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/adjust_key_ctrl.sv
// ----------------------------------------------------------------------------
// adjust_key_ctrl
// Upstream control for the brightness/colour adder. Four debounced keys
// drive a channel-select FSM and four saturating shadow gain levels
// (global, R, G, B). Shadows are committed to the outputs only on a
// vertical-sync rising edge so a level change never tears mid-frame.
// Ports:
//   clk, rst_n                      : pixel clock, async active-low reset
//   key_mode_n/up_n/down_n/clr_n    : raw active-low push-buttons
//   vs_in                           : vertical sync, active-high
//   rgb/r/g/b_ctrl_plus10           : committed levels 0..7
//   sel                             : current channel (0 ALL,1 R,2 G,3 B)
//   pending                         : a shadow differs from its committed level
// ----------------------------------------------------------------------------
module adjust_key_ctrl
   import adjust_pkg::*;
#(
   parameter int DB_CYCLES = 750000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_mode_n,
   input  logic             key_up_n,
   input  logic             key_down_n,
   input  logic             key_clr_n,
   input  logic             vs_in,
   output logic [LVL_W-1:0] rgb_ctrl_plus10,
   output logic [LVL_W-1:0] r_ctrl_plus10,
   output logic [LVL_W-1:0] g_ctrl_plus10,
   output logic [LVL_W-1:0] b_ctrl_plus10,
   output logic [1:0]       sel,
   output logic             pending
);

   function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] lvl);
      return (lvl == LVL_MAX) ? lvl : lvl + LVL_W'(1);
   endfunction

   function automatic logic [LVL_W-1:0] sat_dec(input logic [LVL_W-1:0] lvl);
      return (lvl == '0) ? lvl : lvl - LVL_W'(1);
   endfunction

   logic w_p_mode, w_p_up, w_p_down, w_p_clr;
   logic w_ev_mode, w_ev_up, w_ev_down, w_ev_clr;
   logic w_vs_rise;
   logic w_diff;

   sel_t             r_sel;
   logic [LVL_W-1:0] r_shadow [4];
   logic [LVL_W-1:0] r_commit [4];
   logic             r_vs_d;
   logic             r_pending;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_mode_n), .o_press(w_p_mode));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_up_n), .o_press(w_p_up));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_down_n), .o_press(w_p_down));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_clr_n), .o_press(w_p_clr));

   // Only the highest-priority event of a cycle survives: clr > mode > up > down.
   assign w_ev_clr  = w_p_clr;
   assign w_ev_mode = w_p_mode & ~w_p_clr;
   assign w_ev_up   = w_p_up   & ~w_p_clr & ~w_p_mode;
   assign w_ev_down = w_p_down & ~w_p_clr & ~w_p_mode & ~w_p_up;

   assign w_vs_rise = vs_in & ~r_vs_d;

   // Select FSM: ALL -> R -> G -> B -> ALL, wrapping naturally in 2 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= SEL_ALL;
      end else if (w_ev_mode) begin
         r_sel <= r_sel + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      end else if (w_ev_clr) begin
         for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      end else if (w_ev_up) begin
         r_shadow[r_sel] <= sat_inc(r_shadow[r_sel]);
      end else if (w_ev_down) begin
         r_shadow[r_sel] <= sat_dec(r_shadow[r_sel]);
      end
   end

   // Commit samples the shadows as they stand before this edge, so an event
   // landing on the same edge shows up one frame later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d <= 1'b0;
         for (int i = 0; i < 4; i++) r_commit[i] <= '0;
      end else begin
         r_vs_d <= vs_in;
         if (w_vs_rise) begin
            for (int i = 0; i < 4; i++) r_commit[i] <= r_shadow[i];
         end
      end
   end

   always_comb begin
      w_diff = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (r_shadow[i] != r_commit[i]) w_diff = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= 1'b0;
      else        r_pending <= w_diff;
   end

   assign rgb_ctrl_plus10 = r_commit[0];
   assign r_ctrl_plus10   = r_commit[1];
   assign g_ctrl_plus10   = r_commit[2];
   assign b_ctrl_plus10   = r_commit[3];
   assign sel             = r_sel;
   assign pending         = r_pending;

endmodule

// File: tb/tb_adjust_key_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adjust_key_ctrl
// Self-checking bench for adjust_key_ctrl with DB_CYCLES = 4. A key-level
// model (levels, selected channel, committed values) predicts the outputs
// after each press or vsync; a randomized phase mixes presses of random key
// subsets, glitches and frame commits.
// ----------------------------------------------------------------------------
module tb_adjust_key_ctrl;

   localparam int DB = 4;

   logic       clk;
   logic       rst_n;
   logic       key_mode_n, key_up_n, key_down_n, key_clr_n;
   logic       vs_in;
   logic [2:0] rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10, b_ctrl_plus10;
   logic [1:0] sel;
   logic       pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: index 0 = ALL, 1 = R, 2 = G, 3 = B.
   int m_shadow [4];
   int m_commit [4];
   int m_sel;

   adjust_key_ctrl #(.DB_CYCLES(DB)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .key_mode_n      (key_mode_n),
      .key_up_n        (key_up_n),
      .key_down_n      (key_down_n),
      .key_clr_n       (key_clr_n),
      .vs_in           (vs_in),
      .rgb_ctrl_plus10 (rgb_ctrl_plus10),
      .r_ctrl_plus10   (r_ctrl_plus10),
      .g_ctrl_plus10   (g_ctrl_plus10),
      .b_ctrl_plus10   (b_ctrl_plus10),
      .sel             (sel),
      .pending         (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_diff();
      int d;
      d = 0;
      for (int i = 0; i < 4; i++) if (m_shadow[i] != m_commit[i]) d = 1;
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = 0;
         m_commit[i] = 0;
      end
      m_sel = 0;
   endtask

   // mask bits: 0 up, 1 down, 2 mode, 3 clr
   task automatic model_event(input logic [3:0] mask);
      if (mask[3]) begin
         for (int i = 0; i < 4; i++) m_shadow[i] = 0;
      end else if (mask[2]) begin
         m_sel = (m_sel + 1) % 4;
      end else if (mask[0]) begin
         if (m_shadow[m_sel] < 7) m_shadow[m_sel]++;
      end else if (mask[1]) begin
         if (m_shadow[m_sel] > 0) m_shadow[m_sel]--;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rgb"}, 32'(rgb_ctrl_plus10), 32'(m_commit[0]));
      check({tag, ".r"},   32'(r_ctrl_plus10),   32'(m_commit[1]));
      check({tag, ".g"},   32'(g_ctrl_plus10),   32'(m_commit[2]));
      check({tag, ".b"},   32'(b_ctrl_plus10),   32'(m_commit[3]));
      check({tag, ".sel"}, 32'(sel),             32'(m_sel));
      check({tag, ".pending"}, 32'(pending),     32'(model_diff()));
   endtask

   task automatic drive_keys(input logic [3:0] mask);
      key_up_n   = ~mask[0];
      key_down_n = ~mask[1];
      key_mode_n = ~mask[2];
      key_clr_n  = ~mask[3];
   endtask

   // Hold the keys in mask low for 'hold' cycles, then release and settle.
   task automatic press(input string tag, input logic [3:0] mask, input int hold);
      int   d_before;
      logic seen;
      d_before = model_diff();
      @(negedge clk);
      drive_keys(mask);
      seen = pending;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         seen = seen | pending;
      end
      drive_keys(4'b0000);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         seen = seen | pending;
      end
      if (hold >= DB) model_event(mask);
      check({tag, ".pend_seen"}, 32'(seen), 32'(d_before | model_diff()));
      check_all(tag);
   endtask

   task automatic vsync(input string tag);
      @(negedge clk);
      vs_in = 1'b1;
      repeat (3) @(negedge clk);
      vs_in = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) m_commit[i] = m_shadow[i];
      check_all(tag);
   endtask

   initial begin
      logic [3:0] rmask;
      int         rhold;

      rst_n = 1'b0;
      vs_in = 1'b0;
      drive_keys(4'b0000);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("reset");

      // A 3-cycle low pulse is a glitch and produces nothing.
      press("glitch", 4'b0001, 3);
      vsync("glitch_vs");

      // Long up press: pending before the frame edge, committed after it.
      press("up1", 4'b0001, 20);
      check("up1.pre_rgb", 32'(rgb_ctrl_plus10), 32'd0);
      check("up1.pre_pend", 32'(pending), 32'd1);
      vsync("up1_vs");
      check("up1.post_rgb", 32'(rgb_ctrl_plus10), 32'd1);

      // Select G and drive it into saturation.
      press("mode_r", 4'b0100, 8);
      press("mode_g", 4'b0100, 8);
      check("sel_g", 32'(sel), 32'd2);
      for (int i = 0; i < 9; i++) begin
         press("g_up", 4'b0001, 6);
         vsync("g_vs");
      end
      check("g_sat", 32'(g_ctrl_plus10), 32'd7);

      // Back to ALL, bring it to 0, then push down at the floor.
      press("mode_b", 4'b0100, 8);
      press("mode_all", 4'b0100, 8);
      press("all_dn", 4'b0010, 8);
      vsync("all_dn_vs");
      for (int i = 0; i < 3; i++) press("floor_dn", 4'b0010, 8);
      check("floor.rgb", 32'(rgb_ctrl_plus10), 32'd0);

      // Commit R=5, B=2, then clr and up land together.
      press("to_r", 4'b0100, 8);
      for (int i = 0; i < 5; i++) press("r_up", 4'b0001, 7);
      press("to_g", 4'b0100, 8);
      press("to_b", 4'b0100, 8);
      for (int i = 0; i < 2; i++) press("b_up", 4'b0001, 7);
      vsync("rb_vs");
      press("clr_up", 4'b1001, 10);
      check("clr_up.sel", 32'(sel), 32'd3);
      vsync("clr_vs");

      // Up event on the same edge as the vsync rise, B at level 3.
      for (int i = 0; i < 3; i++) press("b3_up", 4'b0001, 6);
      vsync("b3_vs");
      @(negedge clk);
      key_up_n = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      vs_in = 1'b1;
      repeat (3) @(negedge clk);
      key_up_n = 1'b1;
      vs_in    = 1'b0;
      repeat (14) @(negedge clk);
      model_event(4'b0001);
      check("coinc.b_old", 32'(b_ctrl_plus10), 32'd3);
      check_all("coinc");
      vsync("coinc_next");
      check("coinc.b_new", 32'(b_ctrl_plus10), 32'd4);

      // Reset mid-debounce with the up key held through reset release.
      @(negedge clk);
      key_up_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst.b", 32'(b_ctrl_plus10), 32'd0);
      check("arst.g", 32'(g_ctrl_plus10), 32'd0);
      check("arst.sel", 32'(sel), 32'd0);
      check("arst.pending", 32'(pending), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (10) @(negedge clk);
      key_up_n = 1'b1;
      repeat (14) @(negedge clk);
      model_event(4'b0001);
      check_all("held_rst");
      vsync("held_rst_vs");

      // Randomized mix of key subsets, glitches and frame commits.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            vsync("rnd_vs");
         end else begin
            rmask = 4'($urandom_range(1, 15));
            rhold = $urandom_range(1, 12);
            press("rnd", rmask, rhold);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
